// File: rtl/branch_sched_pkg.sv
// Shared definitions for the branch scheduler: compare op codes, FSM encoding
// and register-file sizing. The external comparator uses the same op codes.
package branch_sched_pkg;

    localparam int REG_W    = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic [2:0] {
        OP_BEQ  = 3'd0,
        OP_BNE  = 3'd1,
        OP_BLEZ = 3'd2,
        OP_BLTZ = 3'd3,
        OP_BGEZ = 3'd4,
        OP_BGTZ = 3'd5,
        OP_MOVZ = 3'd6,
        OP_NONE = 3'd7
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Two-operand ops compare rs against rt; the rest only look at rs.
    function automatic logic needs_rt(input op_t op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_MOVZ);
    endfunction

    function automatic logic is_branch_op(input op_t op);
        return op <= OP_BGTZ;
    endfunction

endpackage

// File: rtl/sb_reg_file.sv
// Per-register countdown scoreboard: an entry is busy while its count is
// nonzero. A set on an entry takes priority over that entry's decrement.
module sb_reg_file
    import branch_sched_pkg::*;
#(
    parameter int LAT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_idx,
    input  logic [LAT_W-1:0] set_val,
    input  logic [REG_W-1:0] rd_a_idx,
    input  logic [REG_W-1:0] rd_b_idx,
    output logic             busy_a,
    output logic             busy_b
);

    logic [LAT_W-1:0] cnt [NUM_REGS];

    // Entry 0 is never written, so r0 stays permanently ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (set_en && (set_idx == REG_W'(i))) begin
                    cnt[i] <= set_val;
                end else if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - LAT_W'(1);
                end
            end
        end
    end

    assign busy_a = (rd_a_idx != '0) && (cnt[rd_a_idx] != '0);
    assign busy_b = (rd_b_idx != '0) && (cnt[rd_b_idx] != '0);

endmodule

// File: rtl/branch_sched.sv
// ID-stage branch/movz scheduler: stalls until the compare operands are
// forwardable, then emits one-cycle resolve pulses and counts branches.
module branch_sched
    import branch_sched_pkg::*;
#(
    parameter int LAT_W = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             id_is_br,
    input  logic [2:0]       id_bctrl,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_we,
    input  logic [4:0]       id_dst,
    input  logic [LAT_W-1:0] id_lat,
    output logic [2:0]       cmp_bctrl,
    input  logic             cmp_o,
    output logic             stall,
    output logic             br_taken,
    output logic             movz_we,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output state_t           fsm_state
);

    state_t state, state_nxt;
    op_t    op;
    logic   br_live, busy_rs, busy_rt, ops_ready;
    logic   stall_raw, resolve, id_fire, sb_set, cnt_br;

    assign op        = op_t'(id_bctrl);
    assign br_live   = id_valid && id_is_br;
    assign cmp_bctrl = br_live ? id_bctrl : OP_NONE;
    assign ops_ready = !busy_rs && (!needs_rt(op) || !busy_rt);

    sb_reg_file #(.LAT_W(LAT_W)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (sb_set),
        .set_idx  (id_dst),
        .set_val  (id_lat),
        .rd_a_idx (id_rs),
        .rd_b_idx (id_rt),
        .busy_a   (busy_rs),
        .busy_b   (busy_rt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall_raw = 1'b0;
        resolve   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (br_live) begin
                    if (ops_ready) begin
                        resolve = 1'b1;
                    end else begin
                        stall_raw = 1'b1;
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // A squashed ID instruction abandons the wait without resolving.
                if (!br_live) begin
                    state_nxt = ST_IDLE;
                end else if (!ops_ready) begin
                    stall_raw = 1'b1;
                end else begin
                    resolve   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are gated by rst_n so they drop as soon as reset asserts.
    assign stall     = stall_raw && rst_n;
    assign br_taken  = resolve && rst_n && is_branch_op(op) && cmp_o;
    assign movz_we   = resolve && rst_n && (op == OP_MOVZ) && cmp_o;
    assign id_fire   = id_valid && !stall;
    assign sb_set    = id_fire && id_we && (id_dst != '0);
    assign cnt_br    = resolve && is_branch_op(op);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else if (cnt_br) begin
            if (br_cnt != '1) begin
                br_cnt <= br_cnt + CNT_W'(1);
            end
            if (cmp_o && (taken_cnt != '1)) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_sched.sv
// Self-checking bench for branch_sched: directed hazard scenarios plus random
// instruction streams compared against a cycle-level scoreboard model.
module tb_branch_sched;
    import branch_sched_pkg::*;

    localparam int LAT_W   = 2;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid = 1'b0, id_is_br = 1'b0, id_we = 1'b0, cmp_o = 1'b0;
    logic [2:0]       id_bctrl = 3'd7;
    logic [4:0]       id_rs = '0, id_rt = '0, id_dst = '0;
    logic [LAT_W-1:0] id_lat = '0;
    logic [2:0]       cmp_bctrl;
    logic             stall, br_taken, movz_we;
    logic [CNT_W-1:0] br_cnt, taken_cnt;
    state_t           fsm_state;

    branch_sched #(.LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_is_br(id_is_br),
        .id_bctrl(id_bctrl), .id_rs(id_rs), .id_rt(id_rt), .id_we(id_we),
        .id_dst(id_dst), .id_lat(id_lat), .cmp_bctrl(cmp_bctrl), .cmp_o(cmp_o),
        .stall(stall), .br_taken(br_taken), .movz_we(movz_we),
        .br_cnt(br_cnt), .taken_cnt(taken_cnt), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int sb[32];
    int m_br = 0;
    int m_tk = 0;
    bit exp_stall_q = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_busy(input int r);
        return (r != 0) && (sb[r] != 0);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) sb[r] = 0;
        m_br = 0;
        m_tk = 0;
        exp_stall_q = 0;
    endtask

    // One ID cycle: apply inputs at negedge, compare against the model, then
    // advance the model across the rising edge.
    task automatic drive(input bit v, input bit br, input int op, input int rs, input int rt,
                         input bit we, input int dst, input int lat, input bit c,
                         output bit obs_stall, output bit obs_tk, output bit obs_mz);
        bit live, need, ready, res, e_st, e_tk, e_mz, fire;
        id_valid = v; id_is_br = br; id_bctrl = 3'(op);
        id_rs = 5'(rs); id_rt = 5'(rt); id_we = we; id_dst = 5'(dst);
        id_lat = LAT_W'(lat); cmp_o = c;
        #1;
        live  = v && br;
        need  = (op == 0) || (op == 1) || (op == 6);
        ready = !m_busy(rs) && (!need || !m_busy(rt));
        e_st  = live && !ready;
        res   = live && ready;
        e_tk  = res && (op <= 5) && c;
        e_mz  = res && (op == 6) && c;
        check("cmp_bctrl", cmp_bctrl, live ? op : 7);
        check("stall", stall, e_st);
        check("br_taken", br_taken, e_tk);
        check("movz_we", movz_we, e_mz);
        check("br_cnt", br_cnt, m_br);
        check("taken_cnt", taken_cnt, m_tk);
        obs_stall = stall; obs_tk = br_taken; obs_mz = movz_we;
        exp_stall_q = e_st;
        fire = v && !e_st;
        @(posedge clk);
        for (int r = 1; r < 32; r++) if (sb[r] > 0) sb[r]--;
        if (fire && we && dst != 0) sb[dst] = lat;
        if (res && op <= 5) begin
            if (m_br < CNT_MAX) m_br++;
            if (c && m_tk < CNT_MAX) m_tk++;
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    bit st, tk, mz;
    int saved_br;

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_br_taken", br_taken, 0);
        check("rst_movz_we", movz_we, 0);
        check("rst_br_cnt", br_cnt, 0);
        check("rst_taken_cnt", taken_cnt, 0);
        check("rst_state", fsm_state, ST_IDLE);
        rst_n = 1'b1;
        @(negedge clk);

        // beq r1,r2 with no producers resolves immediately
        drive(1, 1, 0, 1, 2, 0, 0, 0, 1, st, tk, mz);
        check("beq_nostall", st, 0);
        check("beq_taken", tk, 1);
        check("beq_br_cnt", br_cnt, 1);
        check("beq_taken_cnt", taken_cnt, 1);

        // load r3 lat=2, one intervening slot, then bgtz r3: single stall cycle
        drive(1, 0, 7, 0, 0, 1, 3, 2, 0, st, tk, mz);
        drive(0, 0, 7, 0, 0, 0, 0, 0, 0, st, tk, mz);
        drive(1, 1, 5, 3, 0, 0, 0, 0, 1, st, tk, mz);
        check("bgtz_stall", st, 1);
        drive(1, 1, 5, 3, 0, 0, 0, 0, 1, st, tk, mz);
        check("bgtz_resolve_stall", st, 0);
        check("bgtz_resolve_taken", tk, 1);

        // ALU producer lat=1 with the same spacing: no stall
        drive(1, 0, 7, 0, 0, 1, 4, 1, 0, st, tk, mz);
        drive(0, 0, 7, 0, 0, 0, 0, 0, 0, st, tk, mz);
        drive(1, 1, 5, 4, 0, 0, 0, 0, 0, st, tk, mz);
        check("alu_nostall", st, 0);

        // blez ignores rt: busy r6 as rt, and r0 as rt, must not stall
        drive(1, 0, 7, 0, 0, 1, 6, 3, 0, st, tk, mz);
        drive(1, 1, 2, 5, 6, 0, 0, 0, 1, st, tk, mz);
        check("blez_busy_rt_nostall", st, 0);
        drive(1, 1, 2, 5, 0, 0, 0, 0, 0, st, tk, mz);
        check("blez_r0_nostall", st, 0);

        // movz with rt busy lat=3: two stalls, then movz_we, br_cnt unchanged
        drive(1, 0, 7, 0, 0, 1, 7, 3, 0, st, tk, mz);
        drive(0, 0, 7, 0, 0, 0, 0, 0, 0, st, tk, mz);
        saved_br = m_br;
        drive(1, 1, 6, 1, 7, 1, 9, 1, 1, st, tk, mz);
        check("movz_stall1", st, 1);
        drive(1, 1, 6, 1, 7, 1, 9, 1, 1, st, tk, mz);
        check("movz_stall2", st, 1);
        drive(1, 1, 6, 1, 7, 1, 9, 1, 1, st, tk, mz);
        check("movz_resolve_stall", st, 0);
        check("movz_we_pulse", mz, 1);
        check("movz_br_cnt", br_cnt, saved_br);

        // Reset asserted while waiting on r8
        drive(1, 0, 7, 0, 0, 1, 8, 3, 0, st, tk, mz);
        drive(1, 1, 0, 8, 0, 0, 0, 0, 1, st, tk, mz);
        check("wait_entry_stall", st, 1);
        #1;
        check("wait_stall_held", stall, 1);
        check("wait_state", fsm_state, ST_WAIT);
        rst_n = 1'b0;
        #1;
        check("rst_mid_wait_stall", stall, 0);
        check("rst_mid_wait_state", fsm_state, ST_IDLE);
        check("rst_mid_wait_br_cnt", br_cnt, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 0, 8, 0, 0, 0, 0, 1, st, tk, mz);
        check("post_rst_nostall", st, 0);
        check("post_rst_br_cnt", br_cnt, 1);

        // Saturation: 2^CNT_W+1 taken branches from zero
        pulse_reset();
        for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
            drive(1, 1, 1, 0, 0, 0, 0, 0, 1, st, tk, mz);
        end
        check("sat_br_cnt", br_cnt, CNT_MAX);
        check("sat_taken_cnt", taken_cnt, CNT_MAX);

        // Random instruction stream; a stalled instruction is held or squashed
        begin
            bit v, br, we, c;
            int op, rs, rt, dst, lat;
            v = 0; br = 0; we = 0; op = 7; rs = 0; rt = 0; dst = 0; lat = 0;
            for (int n = 0; n < 600; n++) begin
                if (exp_stall_q && $urandom_range(0, 7) == 0) begin
                    v = 0;
                end else if (!exp_stall_q) begin
                    v   = ($urandom_range(0, 5) != 0);
                    br  = $urandom_range(0, 1);
                    op  = $urandom_range(0, 7);
                    rs  = $urandom_range(0, 7);
                    rt  = $urandom_range(0, 7);
                    we  = $urandom_range(0, 1);
                    dst = $urandom_range(0, 7);
                    lat = $urandom_range(0, 3);
                end
                c = $urandom_range(0, 1);
                drive(v, br, op, rs, rt, we, dst, lat, c, st, tk, mz);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
